xunit_msched: RTL and testbench

//  SHA-256 message-schedule unit: the Versat stage directly upstream of the compression-round unit (xunitF).
//  - Consumes one 512-bit block as 16 words W[0..15] on in0.
//  - Emits the expanded schedule W[0..63] on out0, one word per cycle, feeding xunitF in8 (w).
//  - Optionally emits the round constant K[t] on out1, feeding xunitF in9 (k).

---
 rtl/xunit_msched.sv | 117 +++++++++++
 tb/tb_xunit_msched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/xunit_msched.sv
// SHA-256 message-schedule unit: takes W[0..15] on in0 and streams W[0..63] on out0, one word per cycle.
// Define XUNIT_MSCHED_KROM_EN to drive the round constant K[t] on out1; otherwise out1 stays 0.
module xunit_msched #(
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               done,
    input  logic [DATA_W-1:0]  in0,
    output logic [DATA_W-1:0]  out0,
    output logic [DATA_W-1:0]  out1,
    input  logic [DELAY_W-1:0] delay0
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_EXP  = 2'd2;

    logic [1:0]                   state_q, state_d;
    logic [5:0]                   t_q, t_d;
    logic [DELAY_W-1:0]           cnt_q, cnt_d;
    logic [15:0][DATA_W-1:0]      win_q, win_d;
    logic [DATA_W-1:0]            out0_q, out0_d;
    logic [DATA_W-1:0]            out1_q, out1_d;
    logic                         done_q, done_d;
    logic [DATA_W-1:0]            w_new;
    logic [DATA_W-1:0]            k_val;

    function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
        sig0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
        sig1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

`ifdef XUNIT_MSCHED_KROM_EN
    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    assign k_val = K_ROM[t_q];
`else
    assign k_val = '0;
`endif

    // win_q[i] holds W[t-1-i]; taps are W[t-2], W[t-7], W[t-15], W[t-16]
    assign w_new = (t_q < 6'd16) ? in0
                 : sig1(win_q[1]) + win_q[6] + sig0(win_q[14]) + win_q[15];

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        done_d  = done_q;
        if (run) begin
            cnt_d   = delay0;
            t_d     = '0;
            done_d  = 1'b0;
            state_d = (delay0 != '0) ? S_WAIT : S_EXP;
        end else begin
            case (state_q)
                S_WAIT: begin
                    cnt_d = cnt_q - DELAY_W'(1);
                    if (cnt_q == DELAY_W'(1)) state_d = S_EXP;
                end
                S_EXP: begin
                    out0_d = w_new;
                    out1_d = k_val;
                    win_d  = {win_q[14:0], w_new};
                    t_d    = t_q + 6'd1;
                    if (t_q == 6'd63) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            cnt_q   <= '0;
            win_q   <= '0;
            out0_q  <= '0;
            out1_q  <= '0;
            done_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            done_q  <= done_d;
        end
    end

    assign out0 = out0_q;
    assign out1 = out1_q;
    assign done = done_q;

endmodule

// File: tb/tb_xunit_msched.sv
// Randomized scoreboard bench for xunit_msched: expected out0/out1/done per cycle are queued by the
// stimulus from a plain-arithmetic SHA-256 schedule model and checked by an independent monitor.
module tb_xunit_msched;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        done;
    logic [31:0] in0;
    logic [31:0] out0;
    logic [31:0] out1;
    logic [9:0]  delay0;

    xunit_msched dut (
        .clk(clk), .rst(rst), .run(run), .done(done),
        .in0(in0), .out0(out0), .out1(out1), .delay0(delay0)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] o0;
        logic [31:0] o1;
        logic        dn;
    } exp_t;

    exp_t        sbq[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] msg  [16];
    logic [31:0] wexp [64];
    logic [31:0] last_w, last_k;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] kval(input int t);
`ifdef XUNIT_MSCHED_KROM_EN
        logic [31:0] k [64] = '{
            32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
            32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
            32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
            32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
            32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
            32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
            32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
            32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
        };
        return k[t];
`else
        return (t < 0) ? 32'hffffffff : 32'h0;
`endif
    endfunction

    task automatic compute_sched();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) wexp[t] = msg[t];
            else wexp[t] = (rotr(wexp[t-2], 17) ^ rotr(wexp[t-2], 19) ^ (wexp[t-2] >> 10))
                         + wexp[t-7]
                         + (rotr(wexp[t-15], 7) ^ rotr(wexp[t-15], 18) ^ (wexp[t-15] >> 3))
                         + wexp[t-16];
        end
    endtask

    task automatic push(input int c, input logic [31:0] a, input logic [31:0] b, input logic dn);
        exp_t e;
        e.cyc = c; e.o0 = a; e.o1 = b; e.dn = dn;
        sbq.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s cyc=%0d got=%08h want=%08h", name, cyc, act, want);
    endtask

    // Monitor: compares every queued expectation in the cycle it was scheduled for.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.cyc < cyc) chk("missed_slot", 32'(cyc), 32'(e.cyc));
            else begin
                chk("out0", out0, e.o0);
                chk("out1", out1, e.o1);
                chk("done", {31'b0, done}, {31'b0, e.dn});
            end
        end
    end

    // Starts a run in the current cycle; stop>0 ends the task at offset stop without checking that cycle.
    task automatic run_blk(input int d, input int stop);
        logic [31:0] cw, ck;
        run = 1'b1; delay0 = d[9:0]; in0 = $urandom;
        compute_sched();
        for (int i = 1; i <= 65 + d; i++) begin
            @(posedge clk); #1;
            run = 1'b0;
            in0 = (i - 1 - d >= 0 && i - 1 - d < 16) ? msg[i-1-d] : $urandom;
            cw = last_w; ck = last_k;
            if (i - 2 - d >= 0) begin cw = wexp[i-2-d]; ck = kval(i - 2 - d); end
            last_w = cw; last_k = ck;
            if (i == stop) return;
            push(cyc, cw, ck, i == 65 + d);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in0 = $urandom;
            push(cyc, last_w, last_k, 1'b1);
        end
    endtask

    task automatic rand_msg();
        for (int i = 0; i < 16; i++) msg[i] = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int d;
        rst = 1'b1; run = 1'b0; in0 = '0; delay0 = '0;
        last_w = '0; last_k = '0;
        repeat (2) @(posedge clk);
        #1 push(cyc, 32'h0, 32'h0, 1'b1);
        @(posedge clk); #1 rst = 1'b0;
        push(cyc, 32'h0, 32'h0, 1'b1);
        idle(100);

        // "abc" block, no delay
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0] = 32'h61626380; msg[15] = 32'h00000018;
        run_blk(0, 0);
        idle(3);

        @(posedge clk); #1;
        rand_msg();
        run_blk(5, 0);
        idle(3);

        // Abort mid-expansion with a fresh all-zero block
        @(posedge clk); #1;
        rand_msg();
        run_blk(3, 35);
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        run_blk(0, 0);
        idle(2);

        // Restart in the final expansion cycle
        @(posedge clk); #1;
        rand_msg();
        run_blk(2, 66);
        rand_msg();
        run_blk(1, 0);
        idle(2);

        // Asynchronous reset mid-expansion at t=20
        @(posedge clk); #1;
        rand_msg();
        run_blk(4, 26);
        rst = 1'b1;
        #1 push(cyc, 32'h0, 32'h0, 1'b1);
        last_w = '0; last_k = '0;
        @(posedge clk); #1 rst = 1'b0;
        push(cyc, 32'h0, 32'h0, 1'b1);
        idle(8);

        for (int r = 0; r < 4; r++) begin
            @(posedge clk); #1;
            rand_msg();
            d = int'($urandom_range(0, 7));
            run_blk(d, 0);
            idle(int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        if (sbq.size() != 0) chk("drain", 32'(sbq.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
